// File: rtl/mwc_pkg.sv
// mwc_pkg: shared state encoding, entry record and width helpers for mem_write_checker
package mwc_pkg;
  typedef enum logic [2:0] {IDLE, ARMED, PASS, FAIL, TIMEOUT} state_t;
  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
  } exp_entry_t;
  function automatic int iw(int n);
    return n > 1 ? $clog2(n) : 1;
  endfunction
  function automatic int lw(int n);
    return $clog2(n + 1);
  endfunction
endpackage

// File: rtl/mwc_exp_table.sv
// mwc_exp_table: expected-write register file, sync write, comb read, sync active-low clear
module mwc_exp_table
  import mwc_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int NUM_EXP = 4,
  localparam int IW = iw(NUM_EXP),
  localparam int LW = lw(NUM_EXP)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wr_en,
  input  logic [IW-1:0]     wr_idx,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [LW-1:0]     rd_idx,
  output logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data
);
  logic [ADDR_W-1:0] addr_q [NUM_EXP];
  logic [DATA_W-1:0] data_q [NUM_EXP];
  logic [31:0] wi, ri;
  assign wi = 32'(wr_idx);
  assign ri = 32'(rd_idx);
  always_ff @(posedge clk)
    if (!reset) begin
      for (int i = 0; i < NUM_EXP; i++) begin
        addr_q[i] <= '0;
        data_q[i] <= '0;
      end
    end else if (wr_en && wi < 32'(NUM_EXP)) begin
      addr_q[wr_idx] <= wr_addr;
      data_q[wr_idx] <= wr_data;
    end
  // reads past the last entry only happen once the run is over
  assign rd_addr = ri < 32'(NUM_EXP) ? addr_q[rd_idx[IW-1:0]] : '0;
  assign rd_data = ri < 32'(NUM_EXP) ? data_q[rd_idx[IW-1:0]] : '0;
endmodule

// File: rtl/mem_write_checker.sv
// mem_write_checker: checks core memory writes against an ordered expected list.
// Define MWC_IGNORE_EN to let non-matching writes inside the IGN_ADDR/IGN_MASK window pass silently.
module mem_write_checker
  import mwc_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int NUM_EXP = 4,
  parameter int TIMEOUT_CYC = 1000,
  parameter logic [ADDR_W-1:0] IGN_ADDR = ADDR_W'(80),
  parameter logic [ADDR_W-1:0] IGN_MASK = '1,
  localparam int IW = iw(NUM_EXP),
  localparam int LW = lw(NUM_EXP),
  localparam int CW = $clog2(TIMEOUT_CYC + 1)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              we,
  input  logic [ADDR_W-1:0] dataadr,
  input  logic [DATA_W-1:0] writedata,
  input  logic              ld_en,
  input  logic [IW-1:0]     ld_idx,
  input  logic [ADDR_W-1:0] ld_addr,
  input  logic [DATA_W-1:0] ld_data,
  input  logic [LW-1:0]     exp_len,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic              fail,
  output logic              timeout,
  output logic [LW-1:0]     match_cnt,
  output logic [ADDR_W-1:0] fail_addr,
  output logic [DATA_W-1:0] fail_data,
  output logic [CW-1:0]     cycle_cnt
);
`ifdef MWC_IGNORE_EN
  localparam bit IGN_EN = 1'b1;
`else
  localparam bit IGN_EN = 1'b0;
`endif
  state_t state_q, state_d;
  logic [LW-1:0] len_q, len_in, mnext;
  logic [CW-1:0] cnext;
  logic [ADDR_W-1:0] exp_addr;
  logic [DATA_W-1:0] exp_data;
  logic armed, hit, ign, bad, tmo;
  assign armed = state_q == ARMED;
  assign len_in = 32'(exp_len) > 32'(NUM_EXP) ? LW'(NUM_EXP) : exp_len;
  assign hit = we && dataadr == exp_addr && writedata == exp_data;
  assign ign = IGN_EN && ((dataadr & IGN_MASK) == (IGN_ADDR & IGN_MASK));
  assign bad = we && !hit && !ign;
  assign mnext = match_cnt + 1'b1;
  assign cnext = cycle_cnt + 1'b1;
  assign tmo = cnext == CW'(TIMEOUT_CYC);
  mwc_exp_table #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .NUM_EXP(NUM_EXP)) u_table (
    .clk(clk), .reset(reset), .wr_en(ld_en && !armed), .wr_idx(ld_idx),
    .wr_addr(ld_addr), .wr_data(ld_data), .rd_idx(match_cnt),
    .rd_addr(exp_addr), .rd_data(exp_data)
  );
  // a write verdict beats a timeout landing on the same edge
  always_comb begin
    state_d = state_q;
    if (!armed) state_d = start ? (len_in == '0 ? PASS : ARMED) : state_q;
    else state_d = (hit && mnext == len_q) ? PASS : bad ? FAIL : tmo ? TIMEOUT : ARMED;
  end
  always_ff @(posedge clk)
    if (!reset) begin
      state_q   <= IDLE;
      len_q     <= '0;
      match_cnt <= '0;
      cycle_cnt <= '0;
      fail_addr <= '0;
      fail_data <= '0;
    end else begin
      state_q <= state_d;
      if (!armed && start) begin
        len_q     <= len_in;
        match_cnt <= '0;
        cycle_cnt <= '0;
        fail_addr <= '0;
        fail_data <= '0;
      end
      if (armed) begin
        cycle_cnt <= cnext;
        if (hit) match_cnt <= mnext;
        if (bad) begin
          fail_addr <= dataadr;
          fail_data <= writedata;
        end
      end
    end
  assign busy    = armed;
  assign pass    = state_q == PASS;
  assign fail    = state_q == FAIL;
  assign timeout = state_q == TIMEOUT;
  assign done    = pass || fail || timeout;
endmodule

// File: doc/mem_write_checker.md
Name: mem_write_checker

Overview:
- Synthesizable, parametrised monitor on the data-memory write port (we / dataadr / writedata) of a MIPS core.
- Checks memory writes against a loaded, ordered list of expected (address, data) pairs.
- Reports pass, fail (with the offending write captured) or timeout.
- Used by core-level benches and on-FPGA self-test.

Parameters:
- ADDR_W, 32, dataadr width
- DATA_W, 32, writedata width
- NUM_EXP, 4, depth of the expected-write table (≥1)
- TIMEOUT_CYC, 1000, ARMED cycles before timeout (≥1)
- IGN_ADDR, 80, ignore-window base address (used only with MWC_IGNORE_EN)
- IGN_MASK, all-ones, ignore-window compare mask (used only with MWC_IGNORE_EN)

Ports:
- clk  in  1  single clock, all logic on rising edge
- reset  in  1  synchronous, active-low reset (reset==0 at a rising edge resets)
- we  in  1  memory write enable from core
- dataadr  in  ADDR_W  write address
- writedata  in  DATA_W  write data
- ld_en  in  1  table write strobe
- ld_idx  in  IW=$clog2(NUM_EXP)  table index
- ld_addr  in  ADDR_W  expected address
- ld_data  in  DATA_W  expected data
- exp_len  in  LW=$clog2(NUM_EXP+1)  number of entries to check; sampled at start
- start  in  1  arm the checker
- busy  out  1  in ARMED
- done  out  1  in PASS, FAIL or TIMEOUT
- pass  out  1
- fail  out  1
- timeout  out  1
- match_cnt  out  LW  entries matched so far
- fail_addr  out  ADDR_W  captured offending address
- fail_data  out  DATA_W  captured offending data
- cycle_cnt  out  $clog2(TIMEOUT_CYC+1)  ARMED cycles elapsed

Behaviour:
- Reset:
  - State IDLE.
  - All outputs 0; table contents cleared to 0.
  - Reset wins over every other input, including mid-ARMED.
- FSM states: IDLE, ARMED, PASS, FAIL, TIMEOUT.
- Table load:
  - ld_en writes entry ld_idx at the clock edge, only in IDLE or a terminal state; ignored in ARMED.
  - ld_idx ≥ NUM_EXP is ignored.
- Start:
  - start in IDLE or a terminal state → ARMED next cycle.
  - Clears match_cnt, cycle_cnt, fail_addr, fail_data and all flags.
  - Latches len = min(exp_len, NUM_EXP).
  - start and ld_en in the same cycle: the load completes first and is visible to the run.
  - start in ARMED is ignored.
  - If len==0, go directly PASS (one cycle after start).
- ARMED, each cycle, evaluated in this priority order:
  1. we && dataadr==exp[match_cnt].addr && writedata==exp[match_cnt].data → match_cnt++. If the new match_cnt==len → PASS.
  2. we && ignore-hit (see Optional Feature) → no effect.
  3. we otherwise → FAIL; capture dataadr/writedata into fail_addr/fail_data.
  4. No we → no effect.
  - cycle_cnt increments every ARMED cycle. When it would reach TIMEOUT_CYC, go to TIMEOUT, unless the same cycle produced PASS or FAIL (write result wins).
- Matching:
  - Strictly in table order.
  - A write matching a later (not the current) entry is a FAIL.
  - Address and data compare are exact, full width.
- Terminal states are sticky: flags, match_cnt and cycle_cnt hold until start or reset.
- Latency: a write seen at edge N shows in pass/fail/match_cnt after edge N (registered, 1 cycle). No combinational path from inputs to outputs.

Optional Feature:
- Macro MWC_IGNORE_EN.
- Defined: a non-matching write with (dataadr & IGN_MASK)==(IGN_ADDR & IGN_MASK) is ignored (scratch/loop-variable stores). The match check still has priority, so an expected entry inside the window still matches.
- Undefined: the ignore comparator is absent; every non-matching write is a FAIL. IGN_ADDR and IGN_MASK are unused.

Decomposition:
- Package mwc_pkg:
  - state enum (IDLE/ARMED/PASS/FAIL/TIMEOUT)
  - exp_entry_t struct {addr, data}
  - width helper functions for IW/LW
- One sub-module, mwc_exp_table: NUM_EXP-entry register file with synchronous write, combinational read at index match_cnt, synchronous active-low clear.
- FSM, counters and capture registers stay in the top.

Test Plan:
- MWC_IGNORE_EN on, IGN_ADDR=80, load {(84,7)}, len=1, start; writes (80,5), (80,6), (84,7) → pass=1 the cycle after the 84 write, match_cnt=1, fail=0.
- Same table, macro off; write (80,5) → fail=1, fail_addr=80, fail_data=5, pass=0.
- Load {(0x10,1),(0x14,2),(0x18,3)}, len=3; write (0x14,2) first → fail, fail_addr=0x14, match_cnt=0. In-order run → pass, match_cnt=3.
- TIMEOUT_CYC=20, len=1, no writes → timeout=1 with cycle_cnt=20. Matching write exactly on cycle 20 → pass=1, timeout=0.
- Mid-run reset: reset=0 for one edge after 1 of 3 matches → all outputs 0, IDLE; ld_en during ARMED leaves the table unchanged.
- exp_len=0 → pass one cycle after start. exp_len=7 with NUM_EXP=4 → clamped to len=4.
